// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares programMemory's single data port between the CPU LSU (M0) and the
// boot loader / DMA writer (M1). BOOT serves M1 only; RUN round-robins with bounded M1 lock bursts.
module program_memory_arbiter #(
  parameter int MEM_WORDS = 8192,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_done,
  output logic        cpu_hold,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [29:0] mem_address,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_byte_select_vector,
  input  logic [31:0] mem_data_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [29:0]      ADDR_LIMIT = 30'(MEM_WORDS);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             last_m1;
  logic [CNT_W-1:0] burst_cnt;

  logic             lock_hold;
  logic             m0_win;
  logic             m1_win;
  logic             any_gnt;
  logic             sel_we;
  logic [29:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_be;
  logic             in_range;

  logic [29:0]      addr_hold_p1;
  logic [31:0]      wdata_hold_p1;
  logic [3:0]       be_hold_p1;
  logic             rd_vld_p1;
  logic             err_p1;
  logic             owner_p1;
  logic             rd_data_ok;

  function automatic logic [CNT_W-1:0] burst_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= BURST_MAX) ? BURST_MAX : cnt + 1'b1;
  endfunction

  // Stage p0: arbitration and same-cycle memory drive
  always_comb begin
    lock_hold = m1_lock && last_m1 && (burst_cnt < BURST_MAX);
    m0_win    = 1'b0;
    m1_win    = 1'b0;
    if (state == BOOT) begin
      m1_win = m1_req;
    end else if (m0_req && m1_req) begin
      if (lock_hold || rr_ptr) m1_win = 1'b1;
      else                     m0_win = 1'b1;
    end else begin
      m0_win = m0_req;
      m1_win = m1_req;
    end
  end

  assign m0_gnt    = m0_win;
  assign m1_gnt    = m1_win;
  assign any_gnt   = m0_win | m1_win;
  assign sel_we    = m1_win ? m1_we    : m0_we;
  assign sel_addr  = m1_win ? m1_addr  : m0_addr;
  assign sel_wdata = m1_win ? m1_wdata : m0_wdata;
  assign sel_be    = m1_win ? m1_be    : m0_be;
  assign in_range  = sel_addr < ADDR_LIMIT;

  // Out-of-range grants are accepted but never reach the memory strobes.
  assign mem_ren                = any_gnt & ~sel_we & in_range;
  assign mem_wen                = any_gnt &  sel_we & in_range;
  assign mem_address            = any_gnt ? sel_addr  : addr_hold_p1;
  assign mem_data_in            = any_gnt ? sel_wdata : wdata_hold_p1;
  assign mem_byte_select_vector = any_gnt ? sel_be    : be_hold_p1;

  always_ff @(posedge clk) begin
    if (any_gnt) begin
      addr_hold_p1  <= sel_addr;
      wdata_hold_p1 <= sel_wdata;
      be_hold_p1    <= sel_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      cpu_hold  <= 1'b1;
      rr_ptr    <= 1'b0;
      last_m1   <= 1'b0;
      burst_cnt <= '0;
      rd_vld_p1 <= 1'b0;
      err_p1    <= 1'b0;
      owner_p1  <= 1'b0;
    end else begin
      if (state == BOOT && boot_done) begin
        state    <= RUN;
        cpu_hold <= 1'b0;
      end
      if (any_gnt) begin
        rr_ptr  <= m0_win;
        last_m1 <= m1_win;
      end
      burst_cnt <= (m1_win && m1_lock) ? burst_sat_inc(burst_cnt) : '0;
      rd_vld_p1 <= any_gnt & ~sel_we;
      err_p1    <= any_gnt & ~in_range;
      owner_p1  <= m1_win;
    end
  end

  // Stage p1: read return tagged to the owner registered at grant
  assign rd_data_ok = rd_vld_p1 & ~err_p1;
  assign m0_rvalid  = rd_vld_p1 & ~owner_p1;
  assign m1_rvalid  = rd_vld_p1 &  owner_p1;
  assign m0_err     = err_p1 & ~owner_p1;
  assign m1_err     = err_p1 &  owner_p1;
  assign m0_rdata   = (rd_data_ok & ~owner_p1) ? mem_data_out : '0;
  assign m1_rdata   = (rd_data_ok &  owner_p1) ? mem_data_out : '0;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Randomised scoreboard bench for program_memory_arbiter with a behavioural arbitration/memory model.
module tb_program_memory_arbiter;
  localparam int MEM_WORDS = 8192;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        boot_done = 1'b0;
  logic        cpu_hold;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [29:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [29:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [29:0] mem_address;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_byte_select_vector;
  logic [31:0] mem_data_out = '0;

  always #5 clk = ~clk;

  program_memory_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done), .cpu_hold(cpu_hold),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_data_in(mem_data_in),
    .mem_byte_select_vector(mem_byte_select_vector), .mem_data_out(mem_data_out)
  );

  // programMemory stand-in: one-cycle read latency, byte-masked writes
  bit [31:0] env_mem [MEM_WORDS];
  always @(posedge clk) begin
    bit [31:0] w;
    if (mem_wen) begin
      w = env_mem[mem_address[12:0]];
      for (int b = 0; b < 4; b++)
        if (mem_byte_select_vector[b]) w[8*b +: 8] = mem_data_in[8*b +: 8];
      env_mem[mem_address[12:0]] <= w;
    end
    if (mem_ren) mem_data_out <= env_mem[mem_address[12:0]];
  end

  typedef struct {
    int          owner;
    bit          rvalid;
    bit          err;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  bit   [31:0] shadow [MEM_WORDS];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          in_boot;
  int          rr_next, last_owner, run_len;
  bit          g0, g1;
  bit          have_last;
  logic [29:0] last_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    in_boot = 1'b1;
    rr_next = 0;
    last_owner = -1;
    run_len = 0;
    g0 = 1'b0;
    g1 = 1'b0;
    exp_q.delete();
  endtask

  // Reference model: evaluated once per cycle after the request inputs have settled.
  task automatic model_eval();
    int          win;
    bit          we, oor;
    logic [29:0] addr;
    logic [31:0] wdata, w;
    logic [3:0]  be;
    rsp_t        e;
    win = -1;
    if (in_boot) begin
      if (m1_req) win = 1;
    end else if (m0_req && !m1_req) win = 0;
    else if (m1_req && !m0_req) win = 1;
    else if (m0_req && m1_req) begin
      if (m1_lock && last_owner == 1 && run_len < MAX_BURST) win = 1;
      else win = rr_next;
    end
    check("m0_gnt", m0_gnt, win == 0);
    check("m1_gnt", m1_gnt, win == 1);
    check("cpu_hold", cpu_hold, in_boot);
    if (win >= 0) begin
      we    = (win == 1) ? m1_we    : m0_we;
      addr  = (win == 1) ? m1_addr  : m0_addr;
      wdata = (win == 1) ? m1_wdata : m0_wdata;
      be    = (win == 1) ? m1_be    : m0_be;
      oor   = addr >= MEM_WORDS;
      check("mem_ren", mem_ren, !we && !oor);
      check("mem_wen", mem_wen, we && !oor);
      check("mem_address", mem_address, addr);
      if (we) begin
        check("mem_data_in", mem_data_in, wdata);
        check("mem_be", mem_byte_select_vector, be);
      end
      if (!we) begin
        e.owner = win; e.rvalid = 1'b1; e.err = oor;
        e.data = oor ? 32'h0 : shadow[addr[12:0]]; e.due = cyc + 1;
        exp_q.push_back(e);
      end else if (oor) begin
        e.owner = win; e.rvalid = 1'b0; e.err = 1'b1; e.data = 32'h0; e.due = cyc + 1;
        exp_q.push_back(e);
      end else begin
        w = shadow[addr[12:0]];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        shadow[addr[12:0]] = w;
      end
      rr_next = 1 - win;
      last_owner = win;
      have_last = 1'b1;
      last_addr = addr;
    end else begin
      check("idle_strobes", {mem_ren, mem_wen}, 2'b00);
      if (have_last) check("idle_addr_hold", mem_address, last_addr);
    end
    run_len = (win == 1 && m1_lock) ? ((run_len + 1 > MAX_BURST) ? MAX_BURST : run_len + 1) : 0;
    if (in_boot && boot_done) in_boot = 1'b0;
    g0 = (win == 0);
    g1 = (win == 1);
  endtask

  // Monitor: pops the scoreboard whenever a response is due, else requires silent outputs.
  always @(negedge clk) begin : mon
    rsp_t e;
    while (reset && exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check("rsp_missing", 32'(e.due), 32'(cyc));
    end
    if (reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("m0_rvalid", m0_rvalid, e.owner == 0 && e.rvalid);
      check("m1_rvalid", m1_rvalid, e.owner == 1 && e.rvalid);
      check("m0_err", m0_err, e.owner == 0 && e.err);
      check("m1_err", m1_err, e.owner == 1 && e.err);
      check("m0_rdata", m0_rdata, (e.owner == 0) ? e.data : 32'h0);
      check("m1_rdata", m1_rdata, (e.owner == 1) ? e.data : 32'h0);
    end else begin
      check("idle_rsp_flags", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 4'b0000);
      check("idle_rdata", m0_rdata | m1_rdata, 32'h0);
    end
  end

  function automatic logic [29:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 30'(MEM_WORDS - 2 + $urandom_range(0, 5));
    return 30'($urandom_range(0, 31));
  endfunction

  task automatic refill(input int pct);
    if (!m0_req && $urandom_range(0, 99) < pct) begin
      m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1)); m0_addr = rand_addr();
      m0_wdata = $urandom; m0_be = 4'($urandom_range(1, 15));
    end
    if (!m1_req && $urandom_range(0, 99) < pct) begin
      m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1)); m1_addr = rand_addr();
      m1_wdata = $urandom; m1_be = 4'($urandom_range(1, 15));
    end
  endtask

  // One clock: model checks mid-cycle, then granted requests are retired after the edge.
  task automatic step();
    @(negedge clk);
    #1;
    model_eval();
    @(posedge clk);
    #1;
    boot_done = 1'b0;
    if (g0) m0_req = 1'b0;
    if (g1) m1_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m0_req || m1_req) && n < 50) begin
      step();
      n++;
    end
    check("drain_bound", {m0_req, m1_req}, 2'b00);
  endtask

  initial begin
    model_reset();
    have_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_strobes", {mem_ren, mem_wen}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Boot: only the loader is served
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h20; m1_wdata = 32'hDEADBEEF; m1_be = 4'hF;
    step();
    boot_done = 1'b1;
    step();
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h20;
    step();
    step();

    // Continuous contention, no lock: strict alternation
    m1_lock = 1'b0;
    repeat (16) begin refill(100); step(); end
    // Continuous contention with lock: bursts capped at MAX_BURST
    m1_lock = 1'b1;
    repeat (30) begin refill(100); step(); end
    m1_lock = 1'b0;
    drain();

    // Out-of-range read and write
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'(MEM_WORDS);
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'(MEM_WORDS + 3); m1_wdata = 32'h12345678; m1_be = 4'hF;
    step();
    step();

    // Random traffic
    repeat (400) begin
      m1_lock = 1'($urandom_range(0, 1));
      refill(60);
      step();
    end
    m1_lock = 1'b0;
    drain();
    step();

    // Reset while a read is outstanding
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h20;
    step();
    reset = 1'b0;
    model_reset();
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    check("midrst_cpu_hold", cpu_hold, 1'b1);
    check("midrst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h4;
    repeat (4) step();
    m0_req = 1'b0;
    step();

    repeat (2) @(negedge clk);
    #2;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
